// File: rtl/fp16_add_responder.sv
// fp16_add_responder: fixed-function responder for the start/done float-add mailbox.
// After start falls it reads two binary16 operands (bytes 128..131, MSB first)
// over a synchronous byte port. It adds their magnitudes with truncation and
// writes the 16-bit result to bytes 132/133. It then holds done until start rises.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   request level; a high-to-low transition launches one operation
//   done       out  registered completion flag
//   mem_addr   out  8-bit byte address (holds its last value when idle)
//   mem_wr_en  out  one-cycle write strobe per result byte
//   mem_wdata  out  write data, valid with mem_wr_en
//   mem_rdata  in   read data, valid one cycle after its address
module fp16_add_responder (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic       mem_wr_en,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);
    localparam int unsigned AW = 8;
    localparam int unsigned EW = 5;
    localparam int unsigned MW = 11;
    localparam logic [AW-1:0] OP_BASE  = AW'(128);
    localparam logic [AW-1:0] RES_BASE = AW'(132);

    typedef enum logic [3:0] {
        S_IDLE, S_ARMED, S_RD0, S_RD1, S_RD2, S_RD3, S_RD4,
        S_ALIGN, S_ADD, S_NORM, S_WR0, S_WR1, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          wr_en_q, wr_en_d;
    logic          done_q, done_d;

    // flt2's sign never affects the result, so only its 15 magnitude bits are kept
    logic [15:0]   flt1_q;
    logic [14:0]   flt2_q;
    logic          sign_q;
    logic [EW-1:0] exp_q;
    logic [MW-1:0] big_m_q, small_m_q;
    logic [MW:0]   sum_q;
    logic [15:0]   res_q;

    logic [EW-1:0] e1_c, e2_c, diff_c;
    logic [MW-1:0] m1_c, m2_c;
    logic          flt1_big_c;
    logic [EW:0]   exp_n_c;
    logic [9:0]    frac_c;
    logic [15:0]   res_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)  state_d = S_ARMED;
            S_ARMED: if (!start) state_d = S_RD0;
            S_RD0:   state_d = S_RD1;
            S_RD1:   state_d = S_RD2;
            S_RD2:   state_d = S_RD3;
            S_RD3:   state_d = S_RD4;
            S_RD4:   state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  state_d = S_WR0;
            S_WR0:   state_d = S_WR1;
            S_WR1:   state_d = S_DONE;
            S_DONE:  if (start)  state_d = S_ARMED;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic, decoded from the next state so the ports come straight off flops
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_en_d = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            S_RD0: addr_d = OP_BASE;
            S_RD1: addr_d = OP_BASE + AW'(1);
            S_RD2: addr_d = OP_BASE + AW'(2);
            S_RD3: addr_d = OP_BASE + AW'(3);
            S_WR0: begin
                // entered only from NORM, so res_c is the fresh result
                addr_d  = RES_BASE;
                wr_en_d = 1'b1;
                wdata_d = res_c[15:8];
            end
            S_WR1: begin
                addr_d  = RES_BASE + AW'(1);
                wr_en_d = 1'b1;
                wdata_d = res_q[7:0];
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wr_en = wr_en_q;
    assign done      = done_q;

    // Unpack: a zero exponent field means no hidden bit and effective exponent 1
    always_comb begin
        e1_c       = (flt1_q[14:10] == '0) ? EW'(1) : flt1_q[14:10];
        e2_c       = (flt2_q[14:10] == '0) ? EW'(1) : flt2_q[14:10];
        m1_c       = {(flt1_q[14:10] != '0), flt1_q[9:0]};
        m2_c       = {(flt2_q[14:10] != '0), flt2_q[9:0]};
        flt1_big_c = (e1_c >= e2_c);
        diff_c     = flt1_big_c ? (e1_c - e2_c) : (e2_c - e1_c);
    end

    // Normalize: a carry drops the LSB and bumps the exponent.
    // With no carry and no bit 10, the big operand was subnormal, so the field is 0.
    always_comb begin
        if (sum_q[MW]) begin
            frac_c  = sum_q[10:1];
            exp_n_c = {1'b0, exp_q} + (EW+1)'(1);
        end else begin
            frac_c  = sum_q[9:0];
            exp_n_c = sum_q[MW-1] ? {1'b0, exp_q} : '0;
        end
        if (exp_n_c >= (EW+1)'(31)) res_c = {sign_q, 5'h1F, 10'h000};
        else                        res_c = {sign_q, exp_n_c[EW-1:0], frac_c};
    end

    // Datapath: operand capture, align, add, normalize
    always_ff @(posedge clk) begin
        if (reset) begin
            flt1_q    <= '0;
            flt2_q    <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            big_m_q   <= '0;
            small_m_q <= '0;
            sum_q     <= '0;
            res_q     <= '0;
        end else begin
            case (state_q)
                S_RD1: flt1_q[15:8] <= mem_rdata;
                S_RD2: flt1_q[7:0]  <= mem_rdata;
                S_RD3: flt2_q[14:8] <= mem_rdata[6:0];
                S_RD4: flt2_q[7:0]  <= mem_rdata;
                S_ALIGN: begin
                    sign_q <= flt1_q[15];
                    // shifts of 11 or more leave the small mantissa zero
                    if (flt1_big_c) begin
                        exp_q     <= e1_c;
                        big_m_q   <= m1_c;
                        small_m_q <= m2_c >> diff_c;
                    end else begin
                        exp_q     <= e2_c;
                        big_m_q   <= m2_c;
                        small_m_q <= m1_c >> diff_c;
                    end
                end
                S_ADD:  sum_q <= {1'b0, big_m_q} + {1'b0, small_m_q};
                S_NORM: res_q <= res_c;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp16_add_responder.sv
// Bench for fp16_add_responder: byte memory model, table vectors, a mid-read reset,
// and randomized operands checked against an integer-arithmetic reference.
module tb_fp16_add_responder;
    logic       clk = 1'b0;
    logic       reset, start, done, mem_wr_en;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    fp16_add_responder dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous byte memory; the bench preloads it through its own write port
    logic [7:0] mem [0:255];
    logic       tb_we = 1'b0, cnt_clr = 1'b0;
    logic [7:0] tb_a = '0, tb_d = '0;
    int         wr_cnt = 0, bad_wr = 0;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (tb_we) mem[tb_a] <= tb_d;
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (cnt_clr) begin
            wr_cnt <= 0;
            bad_wr <= 0;
        end else if (mem_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            if (mem_addr != 8'd132 && mem_addr != 8'd133) bad_wr <= bad_wr + 1;
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_a = a; tb_d = d;
        tick();
        tb_we = 1'b0;
    endtask

    // Reference: exact integer sum on the big operand's grid, floored, then truncated to 11 bits
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, e_big, m_big, m_sm, d, e, fld;
        longint acc;
        ea = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
        eb = (b[14:10] == 5'd0) ? 1 : int'(b[14:10]);
        ma = ((a[14:10] == 5'd0) ? 0 : 1024) + int'(a[9:0]);
        mb = ((b[14:10] == 5'd0) ? 0 : 1024) + int'(b[9:0]);
        if (ea >= eb) begin e_big = ea; m_big = ma; m_sm = mb; d = ea - eb; end
        else          begin e_big = eb; m_big = mb; m_sm = ma; d = eb - ea; end
        acc = ((longint'(m_big) << d) + longint'(m_sm)) >> d;
        e = e_big;
        while (acc >= 2048) begin
            acc = acc >> 1;
            e++;
        end
        fld = (acc < 1024) ? 0 : e;
        if (e >= 31) return {a[15], 5'h1F, 10'h000};
        return {a[15], 5'(fld), 10'(acc)};
    endfunction

    // One full handshake; expects the block in IDLE or DONE on entry
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] want, input string tag, input bit was_done);
        int lat;
        start = 1'b1;
        poke(8'd128, a[15:8]);
        if (was_done) chk({tag, "_done_drop"}, 32'(done), 32'd0);
        poke(8'd129, a[7:0]);
        poke(8'd130, b[15:8]);
        poke(8'd131, b[7:0]);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        start = 1'b0;
        tick();  // edge E: ARMED samples start low
        chk({tag, "_addr0"}, 32'(mem_addr), 32'd128);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'd10);
        chk({tag, "_writes"}, 32'(wr_cnt), 32'd2);
        chk({tag, "_stray_writes"}, 32'(bad_wr), 32'd0);
        chk({tag, "_result"}, 32'({mem[132], mem[133]}), 32'(want));
        chk({tag, "_operands"}, {mem[128], mem[129], mem[130], mem[131]}, {a, b});
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [15:0] ra, rb;
        vecs[0]  = '{16'h1A04, 16'h1A04, 16'h1E04};
        vecs[1]  = '{16'h4A10, 16'h4204, 16'h4B91};
        vecs[2]  = '{16'h3C00, 16'h3C01, 16'h4000};
        vecs[3]  = '{16'h7BFF, 16'h7BFF, 16'h7C00};
        vecs[4]  = '{16'h4A10, 16'h1604, 16'h4A10};
        vecs[5]  = '{16'hC000, 16'h3C00, 16'hC200};
        vecs[6]  = '{16'h0200, 16'h0200, 16'h0400};
        vecs[7]  = '{16'h0001, 16'h0002, 16'h0003};
        vecs[8]  = '{16'h3C00, 16'h4000, 16'h4200};
        vecs[9]  = '{16'h4204, 16'h4A10, 16'h4B91};
        vecs[10] = '{16'h3C00, 16'hBC00, 16'h4000};
        vecs[11] = '{16'h0000, 16'h0000, 16'h0000};

        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        reset = 1'b0;
        tick();

        // Twelve back-to-back table operations
        for (int i = 0; i < 12; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].r, $sformatf("vec%0d", i), i != 0);

        // Reset while reading operand bytes (state RD2)
        start = 1'b1;
        poke(8'd132, 8'hAA);
        poke(8'd133, 8'hBB);
        poke(8'd128, 8'h3C);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        start = 1'b0;
        tick();  // E
        tick();  // RD1
        tick();  // RD2
        reset = 1'b1;
        tick();
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        repeat (15) tick();
        chk("midrst_no_writes", 32'(wr_cnt), 32'd0);
        chk("midrst_msb_kept", 32'(mem[132]), 32'hAA);
        chk("midrst_lsb_kept", 32'(mem[133]), 32'hBB);
        chk("midrst_idle_done", 32'(done), 32'd0);

        // Randomized operands against the reference model
        run_op(16'h3C00, 16'h3C01, 16'h4000, "post_rst", 1'b0);
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 3 == 0) rb[14:10] = ra[14:10] - 5'(i % 4);
            run_op(ra, rb, ref_add(ra, rb), $sformatf("rnd%0d_%h_%h", i, ra, rb), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp16_add_responder.md
# fp16_add_responder

Hardware responder for the program-3 float-addition handshake: a fixed-function engine that services the same `start`/`done` protocol and data-memory mailbox the bench drives. It serves as the hardware golden model next to `tinyarch` in the same harness. After the bench releases `start`, it reads two IEEE binary16 operands from data memory through a single byte port. It adds them with truncation (no rounding), writes the 16-bit result back, and raises `done`.

## Interface
- `OP_BASE`, 128: byte address of operand 1 MSB. Operand bytes are at `OP_BASE..OP_BASE+3`, MSB first.
- `RES_BASE`, 132: byte address of the result MSB. The LSB is at `RES_BASE+1`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  request level from the bench. High = loading/idle; a high-to-low transition launches one operation.
- `done`  out  1  registered. High from operation completion until `start` is next sampled high.
- `mem_addr`  out  8  byte address to the data memory.
- `mem_wr_en`  out  1  write strobe, one cycle per byte.
- `mem_wdata`  out  8  write data.
- `mem_rdata`  in  8  read data. Synchronous memory: data for the address presented in cycle N is valid in cycle N+1.

## Operation
- **Reset values:**
  - `done`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wdata`=0.
  - State = IDLE.
  - Operand/result registers cleared.
- **States and transitions (one cycle each unless noted):**
  - IDLE: go to ARMED when `start`=1.
  - ARMED: wait here while `start`=1; go to RD0 when `start`=0.
  - RD0..RD3: present addresses `OP_BASE+0..3`.
  - RD4: capture the last byte. Each byte is captured one cycle after its address.
  - ALIGN → ADD → NORM.
  - WR0: write the result MSB to `RES_BASE`.
  - WR1: write the result LSB to `RES_BASE+1`.
  - DONE: `done`=1. Stay until `start`=1, then clear `done` and go to ARMED.
- **Unpacking:**
  - Exponent field 0 → hidden bit 0, effective exponent 1.
  - Otherwise → hidden bit 1, effective exponent = field value.
  - This gives two 11-bit mantissas.
- **ALIGN:**
  - The operand with the larger effective exponent is the big one. On a tie, flt1 is big.
  - Right-shift the small mantissa by the exponent difference and discard the bits shifted out.
  - A difference ≥ 11 makes the small mantissa zero.
- **ADD:** 12-bit sum of the two mantissas.
- **NORM:**
  - If sum[11]=1: mantissa = sum[11:1] (truncate the LSB), exponent+1.
  - If the result exponent field is 0 and sum[10]=1: exponent field becomes 1.
- **Overflow:** if the exponent reaches 31, the result is {sign, 5'h1F, 10'b0}.
- **Sign:** the result sign is always flt1's sign. Magnitude subtraction is out of scope.
  - Differing input signs are still added as magnitudes.
  - No NaN/Inf input handling: exponent field 31 inputs are treated as ordinary values.
- **Memory writes:** the block never writes any address other than `RES_BASE` and `RES_BASE+1`, and issues exactly two writes per operation.

## Timing
- **Fixed latency:** with E = the edge at which ARMED samples `start`=0:
  - `mem_addr`=`OP_BASE` during the cycle after E.
  - The MSB write occurs at edge E+9 and the LSB write at edge E+10.
  - `done` goes high at edge E+10 and stays high.
- **Write cycles:** `mem_wr_en` is high only in WR0/WR1, with `mem_wdata` valid in the same cycle.
- **Address when not reading/writing:** `mem_addr` holds its last value; `mem_wr_en`=0.
- **`start` changes mid-operation:** `start` reasserted anywhere from RD0 to WR1 is ignored and the operation completes. If `start` is still high at DONE, `done` is held for exactly one cycle.
- **Reset mid-operation:** the block returns to IDLE on the next edge with all outputs at reset values. No partial write follows.
- **Back-to-back operations** need no idle cycles beyond the ARMED state.

## Test plan
- 0x1A04 + 0x1A04 → `done` at E+10; memory [132]=0x1E, [133]=0x04.
- 0x4A10 + 0x4204 (exponent difference 2) → 0x4B91; addresses 128–131 are unchanged after the operation.
- 0x3C00 + 0x3C01 → 0x4000 (carry-out normalize with truncation). Check that exactly two `mem_wr_en` pulses occur.
- 0x7BFF + 0x7BFF → 0x7C00 (overflow). Also 0x4A10 + 0x1604 (exponent difference 13) → 0x4A10.
- Reset asserted while in RD2 → next cycle `done`=0, `mem_wr_en`=0. The state stays IDLE until `start` rises; [132]/[133] are not written.
- Twelve back-to-back operations using the same start-high/low pattern → each result is correct and each has latency E+10. `done` drops the cycle after `start` rises.
